// File: rtl/button_ctrl.sv
// N-channel push-button front end: synchronise, debounce and emit press, release and
// long-press pulses, plus a sticky active-low reconfiguration request from one channel.
module button_ctrl #(
  parameter int unsigned      N_BTN           = 4,
  parameter logic [N_BTN-1:0] ACTIVE_LOW      = {N_BTN{1'b1}},
  parameter int unsigned      DEBOUNCE_CYCLES = 16,
  parameter int unsigned      LONG_CYCLES     = 1000,
  parameter int unsigned      RECONF_CH       = 0,
  parameter int unsigned      W_CNT           = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic             reconf_en,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] press,
  output logic [N_BTN-1:0] released,
  output logic [N_BTN-1:0] long_press,
  output logic             reconf_n
);

  localparam int unsigned W_IDX = (N_BTN > 1) ? $clog2(N_BTN) : 1;
  localparam logic [W_CNT-1:0] DB_LAST   = W_CNT'(DEBOUNCE_CYCLES - 1);
  localparam logic [W_CNT-1:0] LONG_LAST = W_CNT'(LONG_CYCLES - 1);
  localparam logic [W_CNT-1:0] LONG_MAX  = W_CNT'(LONG_CYCLES);

  logic [N_BTN-1:0] sync1;
  logic [N_BTN-1:0] sync2;
  logic [N_BTN-1:0] pressed_c;
  logic [N_BTN-1:0] toggle_c;
  logic [W_CNT-1:0] db   [N_BTN];
  logic [W_CNT-1:0] hold [N_BTN];

  // Synchronised input normalised to 1 = pressed.
  assign pressed_c = sync2 ^ ACTIVE_LOW;

  // Level flips on the edge where the mismatch run would reach the debounce length.
  always_comb begin
    toggle_c = '0;
    for (int i = 0; i < int'(N_BTN); i++) begin
      toggle_c[i] = (pressed_c[i] != btn_level[i]) && (db[i] == DB_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1      <= ACTIVE_LOW;
      sync2      <= ACTIVE_LOW;
      btn_level  <= '0;
      press      <= '0;
      released   <= '0;
      long_press <= '0;
      reconf_n   <= 1'b1;
      for (int i = 0; i < int'(N_BTN); i++) begin
        db[i]   <= '0;
        hold[i] <= '0;
      end
    end else begin
      sync1     <= btn_raw;
      sync2     <= sync1;
      btn_level <= btn_level ^ toggle_c;
      press     <= toggle_c & ~btn_level;
      released  <= toggle_c & btn_level;

      for (int i = 0; i < int'(N_BTN); i++) begin
        if (toggle_c[i] || (pressed_c[i] == btn_level[i])) begin
          db[i] <= '0;
        end else begin
          db[i] <= db[i] + W_CNT'(1);
        end

        // Hold count restarts on either level change and saturates so long_press fires once.
        if (toggle_c[i]) begin
          hold[i] <= '0;
        end else if (btn_level[i] && (hold[i] != LONG_MAX)) begin
          hold[i] <= hold[i] + W_CNT'(1);
        end

        long_press[i] <= btn_level[i] && !toggle_c[i] && (hold[i] == LONG_LAST);
      end

      if (long_press[W_IDX'(RECONF_CH)] && reconf_en) begin
        reconf_n <= 1'b0;
      end
    end
  end

endmodule
